// File: rtl/mem_arbiter.sv
// Two-master arbiter serialising requests onto one memory port with a fixed WAIT-cycle access window.
// Optional feature: define MEM_ARB_RR_EN for round-robin tie-break (default build is fixed priority, m0 wins).
module mem_arbiter #(
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int WAIT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_ack,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_ack,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT - 1);

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic          last_grant_q, last_grant_d;
    logic          grant_s;

    // Arbitration: pick the winner index among the live requests
    always_comb begin
        grant_s = 1'b0;
        if (m0_req && m1_req) begin
`ifdef MEM_ARB_RR_EN
            grant_s = ~last_grant_q;
`else
            grant_s = 1'b0;
`endif
        end else if (m1_req) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Next-state and datapath update; last_grant_q doubles as the index of the master being served
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_req || m1_req) begin
                    last_grant_d = grant_s;
                    we_d         = grant_s ? m1_we    : m0_we;
                    addr_d       = grant_s ? m1_addr  : m0_addr;
                    wdata_d      = grant_s ? m1_wdata : m0_wdata;
                    cnt_d        = CNT_INIT;
                    state_d      = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    if (!we_q && !last_grant_q) begin
                        rdata0_d = mem_rdata;
                    end else if (!we_q && last_grant_q) begin
                        rdata1_d = mem_rdata;
                    end else begin
                        rdata0_d = rdata0_q;
                    end
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            addr_q       <= {AW{1'b0}};
            wdata_q      <= {DW{1'b0}};
            rdata0_q     <= {DW{1'b0}};
            rdata1_q     <= {DW{1'b0}};
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign mem_rd    = (state_q == ST_ACCESS) && !we_q;
    assign mem_wr    = (state_q == ST_ACCESS) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign m0_ack    = (state_q == ST_RESP) && !last_grant_q;
    assign m1_ack    = (state_q == ST_RESP) && last_grant_q;
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, multi-cycle corner sequences,
// and randomized transactions against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int WAIT = 2;

    logic        clk;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ack, m1_ack;
    logic        mem_rd, mem_wr;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int failures = 0;

    mem_arbiter #(.AW(32), .DW(32), .WAIT(WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r0, r1, we0, we1;
        logic [31:0] a0, a1, wd0, wd1, mrd;
        int          win;
        logic [31:0] rd0, rd1;
    } vec_t;

    vec_t tbl[6];

    // reference model state
    int          mdl_last;
    logic [31:0] mdl_rd0, mdl_rd1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r0, r1, we0, we1,
                                input logic [31:0] a0, a1, wd0, wd1, mrd,
                                input int win, input logic [31:0] rd0, rd1);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.we0 = we0; v.we1 = we1;
        v.a0 = a0; v.a1 = a1; v.wd0 = wd0; v.wd1 = wd1; v.mrd = mrd;
        v.win = win; v.rd0 = rd0; v.rd1 = rd1;
        return v;
    endfunction

    task automatic drive_idle_inputs();
        m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
        m0_addr = 32'h0; m1_addr = 32'h0; m0_wdata = 32'h0; m1_wdata = 32'h0;
        mem_rdata = 32'h0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        m0_req = 1'($urandom); m1_req = 1'($urandom); m0_we = 1'($urandom); m1_we = 1'($urandom);
        m0_addr = $urandom; m1_addr = $urandom; m0_wdata = $urandom; m1_wdata = $urandom;
        mem_rdata = $urandom;
        #1;
        chk("rst_strobes", {62'h0, mem_rd, mem_wr}, 64'h0);
        chk("rst_acks", {62'h0, m0_ack, m1_ack}, 64'h0);
        chk("rst_addr", {32'h0, mem_addr}, 64'h0);
        chk("rst_wdata", {32'h0, mem_wdata}, 64'h0);
        chk("rst_rdata", {m0_rdata, m1_rdata}, 64'h0);
        @(negedge clk);
        @(negedge clk);
        drive_idle_inputs();
        rst_n = 1'b1;
    endtask

    // Starts in an IDLE cycle just after a negedge; returns in the following IDLE cycle after its negedge.
    task automatic run_txn(input string tag, input logic r0, r1, we0, we1,
                           input logic [31:0] a0, a1, wd0, wd1, mrd,
                           input int win, input logic [31:0] erd0, erd1);
        logic        ewe;
        logic [31:0] eaddr, ewd;
        ewe   = (win == 1) ? we1 : we0;
        eaddr = (win == 1) ? a1  : a0;
        ewd   = (win == 1) ? wd1 : wd0;
        m0_req = r0; m1_req = r1; m0_we = we0; m1_we = we1;
        m0_addr = a0; m1_addr = a1; m0_wdata = wd0; m1_wdata = wd1;
        @(posedge clk);
        for (int k = 1; k <= WAIT; k++) begin
            @(negedge clk);
            chk({tag, "_acc_rd"}, {63'h0, mem_rd}, {63'h0, !ewe});
            chk({tag, "_acc_wr"}, {63'h0, mem_wr}, {63'h0, ewe});
            chk({tag, "_acc_addr"}, {32'h0, mem_addr}, {32'h0, eaddr});
            if (ewe) chk({tag, "_acc_wdata"}, {32'h0, mem_wdata}, {32'h0, ewd});
            chk({tag, "_acc_noack"}, {62'h0, m0_ack, m1_ack}, 64'h0);
            // input changes during ACCESS must be ignored
            m0_we = 1'($urandom); m1_we = 1'($urandom);
            m0_addr = $urandom; m1_addr = $urandom; m0_wdata = $urandom; m1_wdata = $urandom;
            mem_rdata = (k == WAIT) ? mrd : ~mrd;
        end
        @(negedge clk);
        chk({tag, "_resp_ack"}, {62'h0, m0_ack, m1_ack}, {62'h0, win == 0, win == 1});
        chk({tag, "_resp_strobe"}, {62'h0, mem_rd, mem_wr}, 64'h0);
        chk({tag, "_resp_rdata0"}, {32'h0, m0_rdata}, {32'h0, erd0});
        chk({tag, "_resp_rdata1"}, {32'h0, m1_rdata}, {32'h0, erd1});
        m0_req = 1'b0; m1_req = 1'b0;
        mem_rdata = $urandom;
        @(negedge clk);
        chk({tag, "_idle"}, {60'h0, mem_rd, mem_wr, m0_ack, m1_ack}, 64'h0);
    endtask

    // Reference arbitration rule
    function automatic int ref_winner(input logic r0, r1);
        if (r0 && r1) begin
`ifdef MEM_ARB_RR_EN
            return (mdl_last == 0) ? 1 : 0;
`else
            return 0;
`endif
        end else if (r1) begin
            return 1;
        end else begin
            return 0;
        end
    endfunction

    initial begin
        int m1_seen;
        int exp_w;
        logic r0, r1, we0, we1;
        logic [31:0] a0, a1, wd0, wd1, mrd;
        int w;

        clk = 1'b0;
        drive_idle_inputs();

        tbl[0] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF,
                    0, 32'hDEADBEEF, 32'h0);
        tbl[1] = mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h20, 32'h0, 32'h12345678, 32'h99998888,
                    1, 32'hDEADBEEF, 32'h0);
        tbl[2] = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h24, 32'h0, 32'h0, 32'hCAFEF00D,
                    1, 32'hDEADBEEF, 32'hCAFEF00D);
        tbl[3] = mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h30, 32'h34, 32'hA5A5A5A5, 32'h0, 32'h0BADF00D,
                    0, 32'hDEADBEEF, 32'hCAFEF00D);
`ifdef MEM_ARB_RR_EN
        tbl[4] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h44, 32'h0, 32'h0, 32'h11112222,
                    1, 32'hDEADBEEF, 32'h11112222);
        tbl[5] = mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h50, 32'h0, 32'h77776666, 32'h0, 32'h33334444,
                    0, 32'hDEADBEEF, 32'h11112222);
`else
        tbl[4] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h44, 32'h0, 32'h0, 32'h11112222,
                    0, 32'h11112222, 32'hCAFEF00D);
        tbl[5] = mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h50, 32'h0, 32'h77776666, 32'h0, 32'h33334444,
                    0, 32'h11112222, 32'hCAFEF00D);
`endif

        // reset and quiet idle
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_idle", {60'h0, mem_rd, mem_wr, m0_ack, m1_ack}, 64'h0);
        end

        // directed vector table
        for (int i = 0; i < 6; i++) begin
            run_txn($sformatf("vec%0d", i), tbl[i].r0, tbl[i].r1, tbl[i].we0, tbl[i].we1,
                    tbl[i].a0, tbl[i].a1, tbl[i].wd0, tbl[i].wd1, tbl[i].mrd,
                    tbl[i].win, tbl[i].rd0, tbl[i].rd1);
        end

        // both requesters held high: grant order
        apply_reset();
        m0_req = 1'b1; m1_req = 1'b1; m0_we = 1'b1; m1_we = 1'b1;
        m0_addr = 32'h100; m1_addr = 32'h200;
        m1_seen = 0;
        for (int t = 0; t < 4; t++) begin
`ifdef MEM_ARB_RR_EN
            exp_w = t % 2;
`else
            exp_w = 0;
`endif
            @(posedge clk);
            repeat (WAIT + 1) @(negedge clk);
            chk($sformatf("held_grant%0d", t), {62'h0, m0_ack, m1_ack},
                {62'h0, exp_w == 0, exp_w == 1});
            if (m1_ack) m1_seen++;
            if (t == 3) begin
                m0_req = 1'b0; m1_req = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("held_idle%0d", t), {62'h0, mem_rd, mem_wr}, 64'h0);
        end
`ifndef MEM_ARB_RR_EN
        chk("held_m1_never", 64'(m1_seen), 64'h0);
`endif

        // reset in the second ACCESS cycle of an m0 read
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h60;
        @(posedge clk);
        @(negedge clk);
        chk("abort_acc1_rd", {63'h0, mem_rd}, 64'h1);
        @(posedge clk);
        #2;
        chk("abort_acc2_rd", {63'h0, mem_rd}, 64'h1);
        rst_n = 1'b0;
        #1;
        chk("abort_rd_drop", {62'h0, mem_rd, mem_wr}, 64'h0);
        chk("abort_addr", {32'h0, mem_addr}, 64'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_noack", {62'h0, m0_ack, m1_ack}, 64'h0);
        end
        m0_req = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_noack_after", {62'h0, m0_ack, m1_ack}, 64'h0);
        run_txn("fresh", 1'b1, 1'b0, 1'b0, 1'b0, 32'h64, 32'h0, 32'h0, 32'h0, 32'h5A5A1234,
                0, 32'h5A5A1234, 32'h0);

        // randomized transactions against the reference model
        apply_reset();
        mdl_last = 1; mdl_rd0 = 32'h0; mdl_rd1 = 32'h0;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                @(negedge clk);
                chk("rnd_quiet", {62'h0, mem_rd, mem_wr}, 64'h0);
            end
            {r1, r0} = 2'($urandom_range(1, 3));
            we0 = 1'($urandom); we1 = 1'($urandom);
            a0 = $urandom; a1 = $urandom; wd0 = $urandom; wd1 = $urandom; mrd = $urandom;
            w = ref_winner(r0, r1);
            if (w == 0 && !we0) mdl_rd0 = mrd;
            if (w == 1 && !we1) mdl_rd1 = mrd;
            mdl_last = w;
            run_txn($sformatf("rnd%0d", n), r0, r1, we0, we1, a0, a1, wd0, wd1, mrd,
                    w, mdl_rd0, mdl_rd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
